// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, LSB first, optional even parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int WIDTH       = 8,
  parameter int PARITY      = 0,
  parameter int STOP        = 1,
  parameter int SAMPLES     = 16,
  parameter int BUF_ADDR_SZ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             busy,
  output logic             TxOut
);
  localparam int BW    = $clog2(SAMPLES);
  localparam int IW    = $clog2(WIDTH + 1);
  localparam int DEPTH = 1 << BUF_ADDR_SZ;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP_BIT} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [BUF_ADDR_SZ-1:0] r_wp, r_rp;
  logic [BUF_ADDR_SZ:0] r_cnt;
  logic [BW-1:0] r_baud;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic r_ovf, r_par, r_tx;
  logic w_push, w_pop, w_bit_end, w_last, w_par_next, w_tx_next;
  assign full      = r_cnt == (BUF_ADDR_SZ + 1)'(DEPTH);
  assign empty     = r_cnt == '0;
  assign overflow  = r_ovf;
  assign busy      = r_state != IDLE;
  assign TxOut     = r_tx;
  assign w_push    = wr_en & ~full;
  assign w_bit_end = r_baud == BW'(SAMPLES - 1);
  assign w_last    = r_idx == IW'(r_state == DATA ? WIDTH - 1 : STOP - 1);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (wr_en && full) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = empty ? IDLE : START;
      START:    w_next = w_bit_end ? DATA : START;
      DATA:     w_next = !(w_bit_end && w_last) ? DATA : (PARITY != 0 ? PAR : STOP_BIT);
      PAR:      w_next = w_bit_end ? STOP_BIT : PAR;
      STOP_BIT: w_next = !(w_bit_end && w_last) ? STOP_BIT : (empty ? IDLE : START);
      default:  w_next = IDLE;
    endcase
  end
  // Any entry into START (from IDLE or straight from the last stop bit) consumes the FIFO head.
  assign w_pop        = (w_next == START) && (r_state != START);
  assign w_shift_next = w_pop ? r_mem[r_rp] : (r_state == DATA && w_bit_end) ? r_shift >> 1 : r_shift;
  assign w_par_next   = w_pop ? 1'b0 : (r_state == DATA && w_bit_end) ? r_par ^ r_shift[0] : r_par;
  assign w_idx_next   = (w_next != r_state) ? '0 : w_bit_end ? r_idx + 1'b1 : r_idx;
  assign w_tx_next    = (w_next == START) ? 1'b0 : (w_next == DATA) ? w_shift_next[0] :
                        (w_next == PAR) ? w_par_next : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_baud  <= (w_next != r_state || r_state == IDLE) ? '0 : r_baud + 1'b1;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx configurations driven by shared writes and checked every cycle
// against a frame-level model (FIFO queue plus a per-clock line-level list).
module tb_uart_tx;
  logic clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [2:0] tx, bsy, fl, em, ov;
  int tests = 0, fails = 0, sc = 0;
  int cw[3] = '{8, 8, 5};
  int cp[3] = '{0, 1, 1};
  int cs[3] = '{1, 1, 2};
  int cm[3] = '{16, 16, 4};
  int cd[3] = '{16, 4, 4};
  logic [7:0] mq[3][16];
  int mh[3], mn[3], lp[3], ll[3], bcnt[3];
  logic lv[3][256];
  logic etx[3], ebusy[3], eovf[3];
  logic h[3][1024];
  logic [9:0] pat = 10'b1101001010;

  always #5 clk = ~clk;

  uart_tx u0 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(fl[0]),
              .empty(em[0]), .overflow(ov[0]), .busy(bsy[0]), .TxOut(tx[0]));
  uart_tx #(.PARITY(1), .BUF_ADDR_SZ(2)) u1 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en),
              .wr_data(wr_data), .full(fl[1]), .empty(em[1]), .overflow(ov[1]), .busy(bsy[1]),
              .TxOut(tx[1]));
  uart_tx #(.WIDTH(5), .PARITY(1), .STOP(2), .SAMPLES(4), .BUF_ADDR_SZ(2)) u2 (.clk(clk),
              .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data[4:0]), .full(fl[2]), .empty(em[2]),
              .overflow(ov[2]), .busy(bsy[2]), .TxOut(tx[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mh[d] = 0; mn[d] = 0; lp[d] = 0; ll[d] = 0;
      etx[d] = 1'b1; ebusy[d] = 1'b0; eovf[d] = 1'b0;
    end
  endtask

  task automatic put(input int d, input logic b, input int k);
    for (int i = 0; i < k; i++) begin
      lv[d][ll[d]] = b;
      ll[d]++;
    end
  endtask

  // One rising edge: a finished (or absent) frame lets the head word start at once;
  // the write is judged against the occupancy seen before the edge.
  task automatic model_edge(input int d);
    int was;
    logic [7:0] w;
    logic par;
    was = mn[d];
    if (lp[d] >= ll[d] && mn[d] > 0) begin
      w = mq[d][mh[d]];
      mh[d] = (mh[d] + 1) % 16;
      mn[d]--;
      lp[d] = 0; ll[d] = 0; par = 1'b0;
      put(d, 1'b0, cm[d]);
      for (int i = 0; i < cw[d]; i++) begin
        put(d, w[i], cm[d]);
        par ^= w[i];
      end
      if (cp[d] != 0) put(d, par, cm[d]);
      put(d, 1'b1, cs[d] * cm[d]);
    end
    ebusy[d] = lp[d] < ll[d];
    etx[d] = ebusy[d] ? lv[d][lp[d]] : 1'b1;
    if (ebusy[d]) lp[d]++;
    if (wr_en) begin
      if (was < cd[d]) begin
        mq[d][(mh[d] + mn[d]) % 16] = wr_data;
        mn[d]++;
      end else eovf[d] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 3; d++) model_edge(d);
    else model_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("tx%0d", d), tx[d], etx[d]);
      chk($sformatf("busy%0d", d), bsy[d], ebusy[d]);
      chk($sformatf("full%0d", d), fl[d], mn[d] == cd[d]);
      chk($sformatf("empty%0d", d), em[d], mn[d] == 0);
      chk($sformatf("overflow%0d", d), ov[d], eovf[d]);
      if (sc < 1024) h[d][sc] = tx[d];
      bcnt[d] += int'(bsy[d]);
    end
    sc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [7:0] v);
    wr_en = 1'b1;
    wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic begin_sc();
    sc = 0;
    for (int d = 0; d < 3; d++) bcnt[d] = 0;
  endtask

  task automatic reset_literals(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_tx%0d", tag, d), tx[d], 1);
      chk($sformatf("%s_busy%0d", tag, d), bsy[d], 0);
      chk($sformatf("%s_empty%0d", tag, d), em[d], 1);
      chk($sformatf("%s_full%0d", tag, d), fl[d], 0);
      chk($sformatf("%s_ovf%0d", tag, d), ov[d], 0);
    end
  endtask

  initial begin
    int zeros;
    model_reset();
    #1 rst_n = 1'b0;
    #2 reset_literals("por");
    @(negedge clk);
    rst_n = 1'b1;
    // Single frame 0xA5; first sample after the write edge is still idle, start bit follows.
    begin_sc();
    write(8'hA5);
    run(199);
    chk("s1_idle_after_write", h[0][0], 1);
    for (int k = 0; k < 10; k++) chk($sformatf("s1_level%0d", k), h[0][1 + k * 16 + 8], pat[k]);
    chk("s1_len0", bcnt[0], 160);
    chk("s1_len1", bcnt[1], 176);
    chk("s1_len2", bcnt[2], 36);
    chk("s1_par_a5", h[1][1 + 9 * 16 + 8], 0);
    // Parity of 0x07 is 1.
    begin_sc();
    write(8'h07);
    run(199);
    chk("s2_par_07", h[1][1 + 9 * 16 + 8], 1);
    chk("s2_len1", bcnt[1], 176);
    // Back-to-back frames with no idle gap.
    begin_sc();
    wr_en = 1'b1;
    wr_data = 8'h55;
    step();
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    run(398);
    chk("s3_last_stop", h[0][160], 1);
    chk("s3_second_start", h[0][161], 0);
    chk("s3_busy0", bcnt[0], 320);
    chk("s3_busy1", bcnt[1], 352);
    // Fill a 4-deep FIFO during a frame, then one more write.
    begin_sc();
    write(8'h11);
    run(3);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h21 + 8'(i);
      step();
      if (i == 3) chk("s4_full_after_4th", fl[1], 1);
      if (i == 4) begin
        chk("s4_overflow1", ov[1], 1);
        chk("s4_overflow0", ov[0], 0);
      end
    end
    wr_en = 1'b0;
    run(1000);
    chk("s4_busy0", bcnt[0], 960);
    chk("s4_busy1", bcnt[1], 880);
    chk("s4_busy2", bcnt[2], 180);
    // Asynchronous reset in the middle of a frame with a word still queued.
    begin_sc();
    wr_en = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_data = 8'h81;
    step();
    wr_en = 1'b0;
    run(38);
    chk("s5_low_before_rst", h[0][39], 0);
    chk("s5_queued_before_rst", em[0], 0);
    #2 rst_n = 1'b0;
    #1 reset_literals("mid");
    model_reset();
    run(3);
    rst_n = 1'b1;
    begin_sc();
    run(60);
    zeros = 0;
    for (int k = 0; k < 60; k++) zeros += int'(!h[0][k]);
    chk("s5_quiet_after_rst", zeros, 0);
    chk("s5_busy_after_rst", bcnt[0], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
